// File: rtl/mixcol_pkg.sv
// Shared encodings and GF(2^8) helpers for the MixColumns engine.
package mixcol_pkg;

  localparam logic [1:0] MODE_FWD = 2'b00;
  localparam logic [1:0] MODE_INV = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the multipliers MixColumns/InvMixColumns need are supported.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      4'h2:    return x2;
      4'h3:    return x2 ^ b;
      4'h9:    return x8 ^ b;
      4'hb:    return x8 ^ x2 ^ b;
      4'hd:    return x8 ^ x4 ^ b;
      4'he:    return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mixcol_if.sv
// Valid/ready input and output channels of the MixColumns engine.
interface mixcol_if #(
  parameter int unsigned NCOL = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_mode;
  logic [32*NCOL-1:0]     in_state;
  logic                   out_valid;
  logic                   out_ready;
  logic [32*NCOL-1:0]     out_state;

  modport master (
    output in_valid, in_mode, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_mode, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mixcol_word.sv
// Combinational single-column MixColumns / InvMixColumns; row0 byte in col[31:24].
module mixcol_word
  import mixcol_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] a [4];
  logic [7:0] b;

  always_comb begin
    col_out = '0;
    b       = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      a[r] = col_in[8*(3-r) +: 8];
    end
    for (int unsigned r = 0; r < 4; r++) begin
      if (inv) begin
        b = gmul(a[2'(r)], 4'he) ^ gmul(a[2'(r+1)], 4'hb)
          ^ gmul(a[2'(r+2)], 4'hd) ^ gmul(a[2'(r+3)], 4'h9);
      end else begin
        b = gmul(a[2'(r)], 4'h2) ^ gmul(a[2'(r+1)], 4'h3)
          ^ a[2'(r+2)] ^ a[2'(r+3)];
      end
      col_out[8*(3-r) +: 8] = b;
    end
  end

endmodule

// File: rtl/mixcol_engine.sv
// Sequential MixColumns engine: CPC columns per clock, state rotated through the mixers.
module mixcol_engine
  import mixcol_pkg::*;
#(
  parameter int unsigned NCOL = 4,
  parameter int unsigned CPC  = 1
) (
  input  logic  clk,
  input  logic  reset_n,
  mixcol_if.slave bus,
  output logic  busy
);

  localparam int unsigned W     = 32 * NCOL;
  localparam int unsigned STEPS = (CPC == 0) ? 1 : NCOL / CPC;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (CPC == 0 || CPC > NCOL || (NCOL % CPC) != 0) begin : g_bad_param
    $error("mixcol_engine: CPC must divide NCOL");
  end

  state_e          state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic            inv_q, inv_d;
  logic [CW-1:0]   count_q, count_d;

  logic [32*CPC-1:0] mix_lo;
  logic [W-1:0]      step;
  logic              accept;

  for (genvar g = 0; g < CPC; g++) begin : g_word
    mixcol_word u_word (
      .col_in  (data_q[32*g +: 32]),
      .inv     (inv_q),
      .col_out (mix_lo[32*g +: 32])
    );
  end

  // Mixed low columns go to the top so column 0 returns home after STEPS cycles.
  if (CPC == NCOL) begin : g_rot_full
    assign step = mix_lo;
  end else begin : g_rot
    assign step = {mix_lo, data_q[W-1:32*CPC]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      inv_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) state_d = bus.in_mode[1] ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (count_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_d = bus.in_mode[1] ? ST_DONE : ST_BUSY;
          else              state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    bus.out_valid = (state_q == ST_DONE);
    bus.out_state = data_q;
    busy          = (state_q == ST_BUSY);
    accept        = bus.in_ready && bus.in_valid;
  end

  always_comb begin
    data_d  = data_q;
    inv_d   = inv_q;
    count_d = count_q;
    if (accept) begin
      data_d  = bus.in_state;
      inv_d   = bus.in_mode[0];
      count_d = '0;
    end else if (state_q == ST_BUSY) begin
      data_d  = step;
      count_d = count_q + CW'(1);
    end
  end

endmodule
